// File: rtl/sa_gemm_stream.sv
// Output-stationary systolic GEMM engine: operands stream in one k-slice per
// handshake, skew is generated internally, results drain one row per beat.
module sa_gemm_stream #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 16,
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [K_WIDTH-1:0]          k_len,
  input  logic                        acc_en,
  input  logic                        signed_mode,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]  in_a,
  input  logic [COLS*DATA_WIDTH-1:0]  in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COLS*ACC_WIDTH-1:0]   out_row,
  output logic [IDX_W-1:0]            out_row_idx,
  output logic                        done
);

  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int FC_W      = $clog2(ROWS + COLS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, OUT} state_t;

  // A 1x1 array has nothing in flight after the last accept, so FLUSH is skipped.
  localparam state_t AFTER_FEED = (FLUSH_LEN == 0) ? OUT : FLUSH;

  state_t state, state_d;

  logic [K_WIDTH-1:0] k_len_q, k_cnt;
  logic [FC_W-1:0]    flush_cnt;
  logic [IDX_W-1:0]   row_idx;
  logic               signed_q, done_q;
  logic               accept, clear_acc, last_beat;

  logic [DATA_WIDTH-1:0] a_pe   [ROWS][COLS];
  logic                  a_pe_v [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_pe   [ROWS][COLS];
  logic                  b_pe_v [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_w  [ROWS][COLS];

  assign accept    = in_valid && (state == FEED);
  assign clear_acc = (state == IDLE) && start && !acc_en;
  assign last_beat = (state == OUT) && out_ready && (row_idx == LAST_ROW);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (start) state_d = (k_len != '0) ? FEED : AFTER_FEED;
      FEED:  if (accept && (k_cnt == k_len_q - K_WIDTH'(1))) state_d = AFTER_FEED;
      FLUSH: if (flush_cnt == FC_W'(FLUSH_LEN - 1)) state_d = OUT;
      OUT:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    in_ready  = (state == FEED);
    out_valid = (state == OUT);
    done      = done_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k_len_q   <= '0;
      k_cnt     <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      signed_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k_len_q   <= k_len;
          signed_q  <= signed_mode;
          k_cnt     <= '0;
          flush_cnt <= '0;
          row_idx   <= '0;
        end
        FEED:  if (accept) k_cnt <= k_cnt + K_WIDTH'(1);
        FLUSH: flush_cnt <= flush_cnt + FC_W'(1);
        OUT:   if (out_ready) row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + IDX_W'(1);
        default: ;
      endcase
      done_q <= last_beat;
    end
  end

  // Row i of A is delayed i cycles before entering column 0.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    if (i == 0) begin : g_direct
      assign a_pe[0][0]   = in_a[DATA_WIDTH-1:0];
      assign a_pe_v[0][0] = accept;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sh   [i];
      logic                  sh_v [i];
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int s = 0; s < i; s++) begin
            sh[s]   <= '0;
            sh_v[s] <= 1'b0;
          end
        end else begin
          sh[0]   <= in_a[i*DATA_WIDTH +: DATA_WIDTH];
          sh_v[0] <= accept;
          for (int s = 1; s < i; s++) begin
            sh[s]   <= sh[s-1];
            sh_v[s] <= sh_v[s-1];
          end
        end
      end
      assign a_pe[i][0]   = sh[i-1];
      assign a_pe_v[i][0] = sh_v[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    if (j == 0) begin : g_direct
      assign b_pe[0][0]   = in_b[DATA_WIDTH-1:0];
      assign b_pe_v[0][0] = accept;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sh   [j];
      logic                  sh_v [j];
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int s = 0; s < j; s++) begin
            sh[s]   <= '0;
            sh_v[s] <= 1'b0;
          end
        end else begin
          sh[0]   <= in_b[j*DATA_WIDTH +: DATA_WIDTH];
          sh_v[0] <= accept;
          for (int s = 1; s < j; s++) begin
            sh[s]   <= sh[s-1];
            sh_v[s] <= sh_v[s-1];
          end
        end
      end
      assign b_pe[0][j]   = sh[j-1];
      assign b_pe_v[0][j] = sh_v[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe
      // One extra bit lets a single signed multiplier serve both operand modes.
      logic signed [DATA_WIDTH:0]     a_x, b_x;
      logic signed [2*DATA_WIDTH+1:0] prod;
      logic [ACC_WIDTH-1:0]           acc;

      assign a_x  = {signed_q & a_pe[i][j][DATA_WIDTH-1], a_pe[i][j]};
      assign b_x  = {signed_q & b_pe[i][j][DATA_WIDTH-1], b_pe[i][j]};
      assign prod = a_x * b_x;

      always_ff @(posedge clk) begin
        if (!reset_n)                          acc <= '0;
        else if (clear_acc)                    acc <= '0;
        else if (a_pe_v[i][j] && b_pe_v[i][j]) acc <= acc + ACC_WIDTH'(prod);
      end
      assign acc_w[i][j] = acc;

      if (j < COLS - 1) begin : g_fwd_a
        logic [DATA_WIDTH-1:0] a_r;
        logic                  a_rv;
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            a_r  <= '0;
            a_rv <= 1'b0;
          end else begin
            a_r  <= a_pe[i][j];
            a_rv <= a_pe_v[i][j];
          end
        end
        assign a_pe[i][j+1]   = a_r;
        assign a_pe_v[i][j+1] = a_rv;
      end

      if (i < ROWS - 1) begin : g_fwd_b
        logic [DATA_WIDTH-1:0] b_r;
        logic                  b_rv;
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            b_r  <= '0;
            b_rv <= 1'b0;
          end else begin
            b_r  <= b_pe[i][j];
            b_rv <= b_pe_v[i][j];
          end
        end
        assign b_pe[i+1][j]   = b_r;
        assign b_pe_v[i+1][j] = b_rv;
      end
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < COLS; j++) out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_idx][j];
  end

  assign out_row_idx = row_idx;

endmodule

// File: tb/tb_sa_gemm_stream.sv
// Bench for sa_gemm_stream: directed jobs against a matrix-level model, with a
// per-cycle compare process on the result port and a few literal pins.
module tb_sa_gemm_stream;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KW   = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [KW-1:0]        k_len = '0;
  logic                 acc_en = 1'b0;
  logic                 signed_mode = 1'b0;
  logic                 busy;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_a = '0;
  logic [COLS*DW-1:0]   in_b = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [COLS*AW-1:0]   out_row;
  logic [1:0]           out_row_idx;
  logic                 done;

  sa_gemm_stream #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len), .acc_en(acc_en),
    .signed_mode(signed_mode), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  int a_m [ROWS][4];
  int b_m [4][COLS];
  logic [AW-1:0] model_c [ROWS][COLS];

  task automatic check_output(input string name, input logic [COLS*AW-1:0] act, input logic [COLS*AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out waiting on the DUT", name);
  endtask

  function automatic longint ext8(input int v, input bit sgn);
    logic [7:0] b8;
    b8 = v[7:0];
    if (sgn) return longint'($signed(b8));
    return longint'(b8);
  endfunction

  // C (+)= A*B over k slices, wrapping at the accumulator width.
  task automatic model_job(input int k, input bit acc, input bit sgn);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        if (!acc) model_c[i][j] = '0;
        for (int kk = 0; kk < k; kk++)
          model_c[i][j] = model_c[i][j] + AW'(ext8(a_m[i][kk], sgn) * ext8(b_m[kk][j], sgn));
      end
  endtask

  function automatic logic [COLS*AW-1:0] pack_model(input int r);
    logic [COLS*AW-1:0] v;
    v = '0;
    for (int j = 0; j < COLS; j++) v[j*AW +: AW] = model_c[r][j];
    return v;
  endfunction

  task automatic check_model_row(input string name, input int r, input int e0, input int e1, input int e2, input int e3);
    check_output(name, pack_model(r), {32'(e3), 32'(e2), 32'(e1), 32'(e0)});
  endtask

  task automatic load_test1();
    a_m = '{'{1, 0, -2, 3}, '{4, -1, 5, 6}, '{7, 2, -3, 8}, '{-9, 4, 0, -7}};
    b_m = '{'{2, -3, 1, 4}, '{5, 6, -2, -1}, '{-3, 7, 8, 0}, '{0, 2, -5, 9}};
  endtask

  task automatic drive_slice(input int s, input bit valid);
    in_valid = valid;
    for (int i = 0; i < ROWS; i++) in_a[i*DW +: DW] = valid ? 8'(a_m[i][s]) : 8'($urandom);
    for (int j = 0; j < COLS; j++) in_b[j*DW +: DW] = valid ? 8'(b_m[s][j]) : 8'($urandom);
  endtask

  // Compare process: every OUT cycle is checked against the model row the bench expects next.
  initial begin
    int exp_row;
    bit prev_stall, done_due;
    logic [COLS*AW-1:0] prev_row;
    logic [1:0] prev_idx;
    exp_row = 0; prev_stall = 0; done_due = 0; prev_row = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_row = 0; prev_stall = 0; done_due = 0;
      end else begin
        if (done_due) begin
          check_output("done pulse", done, 1);
          check_output("busy in done cycle", busy, 0);
          if (done) begin done_cnt++; done_cyc = cyc; end
          done_due = 0;
        end else begin
          check_output("no stray done", done, 0);
          if (done) done_cnt++;
        end
        if (out_valid) begin
          check_output("row index", out_row_idx, exp_row);
          check_output($sformatf("row %0d data", exp_row), out_row, pack_model(exp_row));
          if (prev_stall) begin
            check_output("stalled row stable", out_row, prev_row);
            check_output("stalled idx stable", out_row_idx, prev_idx);
          end
          prev_stall = !out_ready;
          prev_row = out_row;
          prev_idx = out_row_idx;
          if (out_ready) begin
            if (exp_row == ROWS - 1) begin exp_row = 0; done_due = 1; end
            else exp_row++;
          end
        end else prev_stall = 0;
      end
    end
  end

  task automatic apply_stimulus(input int k, input bit acc, input bit sgn, input bit bubbles,
                                input int stall, input bit poke_start, input bit junk,
                                input int exp_lat, input int exp_done, input string name);
    int c0, idx, guard, first_ov, stall_cnt, rows;
    bit slot, poked;
    model_job(k, acc, sgn);
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(k); acc_en = acc; signed_mode = sgn; c0 = cyc;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; guard = 0; slot = 1'b1;
    while (idx < k && guard < 200) begin
      drive_slice(idx, slot);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (bubbles) slot = !slot;
      guard++;
    end
    if (guard >= 200) fail_timeout({name, " feed"});
    drive_slice(0, 1'b0);
    in_valid = junk;
    first_ov = -1; rows = 0; stall_cnt = 0; guard = 0; poked = 0;
    while (rows < ROWS && guard < 300) begin
      @(negedge clk);
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        if (out_ready) begin rows++; stall_cnt = 0; end
        else stall_cnt++;
      end
      @(posedge clk); #1;
      out_ready = (stall_cnt >= stall);
      start = 1'b0;
      if (poke_start && first_ov >= 0 && !poked) begin start = 1'b1; poked = 1; end
      if (junk) begin in_valid = 1'b1; in_a = $urandom; in_b = $urandom; end
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (guard >= 300) fail_timeout({name, " drain"});
    @(posedge clk); #1;
    if (exp_lat >= 0) check_output({name, " first out_valid cycle"}, first_ov - c0, exp_lat);
    if (exp_done >= 0) check_output({name, " done cycle"}, done_cyc - c0, exp_done);
    @(negedge clk);
    check_output({name, " idle after done"}, busy, 0);
  endtask

  task automatic reset_mid_feed();
    load_test1();
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(4); acc_en = 1'b1; signed_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drive_slice(s, 1'b1);
      @(posedge clk); #1;
    end
    drive_slice(2, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) model_c[i][j] = '0;
    @(negedge clk);
    check_output("post-reset busy", busy, 0);
    check_output("post-reset in_ready", in_ready, 0);
    check_output("post-reset out_valid", out_valid, 0);
    check_output("post-reset done", done, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) model_c[i][j] = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_output("reset busy", busy, 0);
    check_output("reset in_ready", in_ready, 0);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset done", done, 0);
    check_output("reset out_row", out_row, 0);
    check_output("reset out_row_idx", out_row_idx, 0);

    $display("[TB] test 1: signed k=4");
    load_test1();
    apply_stimulus(4, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 11, 15, "t1");
    check_model_row("model t1 row0", 0, 8, -11, -30, 31);
    check_model_row("model t1 row1", 1, -12, 29, 16, 71);
    check_model_row("model t1 row2", 2, 33, -14, -61, 98);
    check_model_row("model t1 row3", 3, 2, 37, 18, -103);

    $display("[TB] test 2: accumulate");
    apply_stimulus(4, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 11, 15, "t2");
    check_model_row("model t2 row0", 0, 16, -22, -60, 62);
    check_output("model t2 c33", {96'b0, model_c[3][3]}, {96'b0, 32'(-206)});

    $display("[TB] test 3: all-ones operands");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin a_m[i][j] = 255; b_m[i][j] = 255; end
    apply_stimulus(4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 11, 15, "t3u");
    check_output("model t3u c00", {96'b0, model_c[0][0]}, {96'b0, 32'd260100});
    apply_stimulus(4, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 11, 15, "t3s");
    check_output("model t3s c32", {96'b0, model_c[3][2]}, {96'b0, 32'd4});

    $display("[TB] test 5: k=0 with start during OUT");
    d0 = done_cnt;
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 7, 11, "t5");
    check_output("t5 single done", done_cnt - d0, 1);

    $display("[TB] test 4: bubbles and output stalls");
    load_test1();
    apply_stimulus(4, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, -1, -1, "t4");

    $display("[TB] k=0 accumulate keeps held C");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 7, 11, "t5b");
    check_model_row("model t5b row3", 3, 2, 37, 18, -103);

    $display("[TB] test 6: reset mid-feed");
    reset_mid_feed();
    load_test1();
    apply_stimulus(4, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 11, 15, "t6");
    check_model_row("model t6 row1", 1, -12, 29, 16, 71);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
